// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for the 5-stage RV64 pipeline. It takes the
// execute-stage view of ID/EX, the decode-stage source indices and the
// memory / multiplier handshakes. From these it produces the per-register
// hold (write inhibit) and flush (bubble) controls, the PC redirect, a sticky
// memory-wait watchdog and a saturating stall-cycle counter.
//
// Ports
//   clk, rst                      clock; synchronous active-low reset
//   id_rs1_idx/id_rs2_idx         decode source register indices
//   id_rs1_used/id_rs2_used       decode instruction reads that source
//   ex_rd_idx, ex_rmem            ID/EX destination index, ID/EX is a load
//   ex_branch_taken/_target       taken branch/jump resolved in EX, target
//   ex_mul_start, ex_mul_done     multicycle mul/div launch pulse, result valid
//   mem_req_valid, mem_ready      MEM access outstanding, access completes
//   pc_hold .. exmem_hold         inhibit register write
//   ifid_flush .. exmem_flush     load a bubble on the next edge
//   redirect_valid, redirect_pc   PC takes redirect_pc on the next edge
//   mem_timeout                   sticky watchdog error
//   stall_cycles                  saturating count of cycles with pc_hold=1
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int ADDR_W      = 64,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1_idx,
  input  logic [4:0]        id_rs2_idx,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        ex_rd_idx,
  input  logic              ex_rmem,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_branch_target,
  input  logic              ex_mul_start,
  input  logic              ex_mul_done,
  input  logic              mem_req_valid,
  input  logic              mem_ready,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              idex_hold,
  output logic              exmem_hold,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MUL_WAIT = 2'd2
  } state_t;

  // Watchdog is at least 8 bits wide, wider if the timeout needs it.
  localparam int              WD_NEED  = $clog2(MEM_TIMEOUT + 1);
  localparam int              WD_W     = (WD_NEED > 8) ? WD_NEED : 8;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic              ret_mul_q, ret_mul_d;   // 1: MEM_WAIT returns to MUL_WAIT
  logic [WD_W-1:0]   wd_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_q;

  logic mem_stall;
  logic load_use;
  logic eff_mul;
  logic ifid_flush_raw, idex_flush_raw, exmem_flush_raw;

  assign mem_stall = mem_req_valid & ~mem_ready;

  // A multiply is outstanding either in MUL_WAIT or parked behind a memory
  // stall. In the cycle the memory access completes, the interrupted state's
  // rules already apply, so the pipeline does not lose a cycle on release.
  assign eff_mul = (state_q == MUL_WAIT) | ((state_q == MEM_WAIT) & ret_mul_q);

  assign load_use = ex_rmem & (ex_rd_idx != 5'd0) &
                    ((id_rs1_used & (id_rs1_idx == ex_rd_idx)) |
                     (id_rs2_used & (id_rs2_idx == ex_rd_idx)));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d         = state_q;
    ret_mul_d       = ret_mul_q;
    pc_hold         = 1'b0;
    ifid_hold       = 1'b0;
    idex_hold       = 1'b0;
    exmem_hold      = 1'b0;
    ifid_flush_raw  = 1'b0;
    idex_flush_raw  = 1'b0;
    exmem_flush_raw = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;

    if (!rst) begin
      state_d   = RUN;
      ret_mul_d = 1'b0;
    end else if (mem_stall) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      state_d    = MEM_WAIT;
      // A mul launched in the stalling cycle is remembered, not dropped.
      ret_mul_d  = eff_mul | ex_mul_start;
    end else if (eff_mul) begin
      if (ex_mul_done) begin
        state_d = RUN;
      end else begin
        pc_hold         = 1'b1;
        ifid_hold       = 1'b1;
        idex_hold       = 1'b1;
        exmem_flush_raw = 1'b1;
        state_d         = MUL_WAIT;
      end
    end else begin
      state_d = ex_mul_start ? MUL_WAIT : RUN;
      if (ex_branch_taken) begin
        redirect_valid = 1'b1;
        redirect_pc    = ex_branch_target;
        ifid_flush_raw = 1'b1;
        idex_flush_raw = 1'b1;
      end else if (load_use) begin
        pc_hold        = 1'b1;
        ifid_hold      = 1'b1;
        idex_flush_raw = 1'b1;
      end
    end
  end

  // Hold beats flush on the same register: the register keeps its value.
  assign ifid_flush  = ifid_flush_raw  & ~ifid_hold;
  assign idex_flush  = idex_flush_raw  & ~idex_hold;
  assign exmem_flush = exmem_flush_raw & ~exmem_hold;

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;

  // NOTE: reset is sampled on the clock edge only; it is not in the
  // sensitivity list, which keeps every flop a plain synchronous-reset flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      ret_mul_q <= 1'b0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      ret_mul_q <= ret_mul_d;

      // Counts cycles spent in MEM_WAIT; zero on entry, parks at the limit.
      if (state_q != MEM_WAIT) begin
        wd_q <= '0;
      end else if (wd_q < WD_LIMIT) begin
        wd_q <= wd_q + 1'b1;
      end

      if ((state_q == MEM_WAIT) && (wd_q >= WD_LIMIT)) begin
        timeout_q <= 1'b1;
      end

      if (pc_hold && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

endmodule
